intra_mb_scheduler: RTL
=======================

Name: intra_mb_scheduler

Overview:
- Frame-level sequencer for the intra reconstruction datapath.
- Walks macroblocks in raster order and drives mbnumber plus a one-cycle enable into the reconstruction block.
- Waits a fixed datapath latency, then presents a valid/ready result handshake to the downstream writer.
- Supplies per-MB neighbour-availability flags (top/left) so prediction can substitute 128 at frame edges.

Parameters:
- LENGTH, 720, frame rows in pixels.
- WIDTH, 1280, frame columns in pixels.
- MB_SIZE_L, 16, macroblock height in pixels.
- MB_SIZE_W, 16, macroblock width in pixels.
- DP_LATENCY, 2, cycles from enable to datapath output valid; legal range 0..15.
- Derived: MB_ROWS = LENGTH/MB_SIZE_L, MB_COLS = WIDTH/MB_SIZE_W, NUM_MB = MB_ROWS*MB_COLS; NUM_MB must be ≤ 8192.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  pulse; begins a frame when idle.
- frame_abort  in  1  pulse; terminates the frame in progress.
- recon_enable  out  1  one-cycle enable to the reconstruction datapath.
- mbnumber  out  13  current MB index, stable from ISSUE until handshake.
- mb_row  out  8  current MB row index.
- mb_col  out  8  current MB column index.
- top_avail  out  1  mb_row != 0.
- left_avail  out  1  mb_col != 0.
- out_valid  out  1  datapath result ready for mbnumber.
- out_ready  in  1  downstream accepts result.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse after last MB accepted.
- stall_cycles  out  16  backpressure counter (see Optional Feature).

Behaviour:
- States: IDLE, ISSUE, WAIT, OUTPUT, DONE. All outputs registered.
- Reset: state IDLE, mbnumber/mb_row/mb_col 0, all 1-bit outputs 0, stall_cycles 0, latency counter 0. Reset applied mid-frame discards the frame with no frame_done.
- IDLE: frame_start=1 → ISSUE; mbnumber/mb_row/mb_col cleared to 0. frame_start is ignored in every other state.
- ISSUE (cycle T): recon_enable=1 for exactly this cycle. If DP_LATENCY=0 → OUTPUT; otherwise → WAIT with lat_cnt=DP_LATENCY-1.
- WAIT: decrement lat_cnt each cycle; at 0 → OUTPUT. out_valid therefore first asserts at T+DP_LATENCY+1.
- OUTPUT: out_valid=1 and held until out_valid&&out_ready.
  - On handshake, if mbnumber=NUM_MB-1 → DONE.
  - Otherwise advance mbnumber+1 and → ISSUE.
  - out_valid drops the cycle after the handshake.
- Advance rule: mb_col wraps MB_COLS-1→0 with mb_row+1; otherwise mb_col+1. No divider or modulo is used.
- top_avail and left_avail update in the same cycle as mb_row and mb_col.
- DONE: frame_done=1 for one cycle → IDLE. busy deasserts the same cycle the state returns to IDLE.
- Throughput with out_ready held at 1: DP_LATENCY+2 cycles per MB.
- frame_abort in a non-IDLE state:
  - Next state is IDLE and out_valid is cleared.
  - No frame_done is issued.
  - frame_abort takes priority over a same-cycle handshake; that transfer is not counted.
  - frame_abort in IDLE has no effect.
- Simultaneous frame_start and frame_abort in IDLE: the start is taken.

Optional Feature:
- Macro: RECON_PERF_EN.
- Defined:
  - stall_cycles increments on every cycle with out_valid=1 and out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared when frame_start is accepted; holds its value after frame_done.
- Undefined: stall_cycles tied to 0, no counter logic.

Test Plan:
1. LENGTH=32, WIDTH=48, MB 16x16 (6 MBs), DP_LATENCY=2, out_ready=1, frame_start at cycle 0 → recon_enable at cycles 1,5,9,13,17,21; mbnumber 0..5. Expected (row,col): (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). top_avail=0 for MB 0–2. left_avail=0 for MB 0 and 3. frame_done at cycle 25.
2. Same config, out_ready=0 for 7 cycles after the first out_valid → out_valid and mbnumber=0 held stable, no new recon_enable; with RECON_PERF_EN stall_cycles=7, without it 0.
3. DP_LATENCY=0 → out_valid asserts the cycle after recon_enable; MB period 2 cycles; 6 MBs finish in 12 cycles + DONE.
4. frame_abort in the same cycle as the MB 3 handshake → IDLE next cycle, out_valid=0, no frame_done; a new frame_start restarts at mbnumber=0 and stall_cycles clears.
5. frame_start pulsed during WAIT → ignored, sequence unchanged. reset asserted in OUTPUT → all outputs 0 next cycle.
6. Default 720x1280 → final MB mbnumber=3599, mb_row=44, mb_col=79, followed by a frame_done pulse.

Source files
------------

// File: rtl/intra_mb_scheduler.sv
// intra_mb_scheduler
//   Frame-level sequencer for the intra reconstruction datapath. Walks the
//   macroblocks of a frame in raster order, fires a one-cycle recon_enable
//   per MB, waits the fixed datapath latency, then offers the result to the
//   downstream writer through a valid/ready handshake. Neighbour availability
//   flags let prediction substitute 128 at the top and left frame edges.
//
//   Optional feature macro: RECON_PERF_EN (enables the stall_cycles counter;
//   when undefined stall_cycles is tied to zero).
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset
//   frame_start   in   pulse, starts a frame when idle
//   frame_abort   in   pulse, kills the frame in progress
//   recon_enable  out  one-cycle enable to the reconstruction datapath
//   mbnumber      out  [12:0] current MB index
//   mb_row        out  [7:0]  current MB row
//   mb_col        out  [7:0]  current MB column
//   top_avail     out  mb_row != 0
//   left_avail    out  mb_col != 0
//   out_valid     out  datapath result ready for mbnumber
//   out_ready     in   downstream accepts the result
//   busy          out  sequencer not idle
//   frame_done    out  one-cycle pulse after the last MB is accepted
//   stall_cycles  out  [15:0] cycles spent with out_valid && !out_ready
module intra_mb_scheduler #(
  parameter int LENGTH     = 720,
  parameter int WIDTH      = 1280,
  parameter int MB_SIZE_L  = 16,
  parameter int MB_SIZE_W  = 16,
  parameter int DP_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        frame_abort,
  output logic        recon_enable,
  output logic [12:0] mbnumber,
  output logic [7:0]  mb_row,
  output logic [7:0]  mb_col,
  output logic        top_avail,
  output logic        left_avail,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] stall_cycles
);

  localparam int MB_ROWS = LENGTH / MB_SIZE_L;
  localparam int MB_COLS = WIDTH / MB_SIZE_W;
  localparam int NUM_MB  = MB_ROWS * MB_COLS;

  localparam logic [12:0] LAST_MB  = 13'(NUM_MB - 1);
  localparam logic [7:0]  LAST_COL = 8'(MB_COLS - 1);
  localparam logic [3:0]  LAT_LOAD = 4'(DP_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t     state;
  logic [3:0] lat_cnt;

  // Main sequencer. Every output is registered, so each transition also
  // loads the output values that belong to the state being entered.
  // Abort outranks everything else outside IDLE, including a same-cycle
  // handshake, so an aborted transfer never advances mbnumber.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      lat_cnt      <= '0;
      recon_enable <= 1'b0;
      mbnumber     <= '0;
      mb_row       <= '0;
      mb_col       <= '0;
      top_avail    <= 1'b0;
      left_avail   <= 1'b0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      recon_enable <= 1'b0;
      frame_done   <= 1'b0;
      if (frame_abort && state != S_IDLE) begin
        state     <= S_IDLE;
        lat_cnt   <= '0;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (frame_start) begin
              state        <= S_ISSUE;
              recon_enable <= 1'b1;
              busy         <= 1'b1;
              mbnumber     <= '0;
              mb_row       <= '0;
              mb_col       <= '0;
              top_avail    <= 1'b0;
              left_avail   <= 1'b0;
            end
          end
          S_ISSUE: begin
            if (DP_LATENCY == 0) begin
              state     <= S_OUTPUT;
              out_valid <= 1'b1;
            end else begin
              state   <= S_WAIT;
              lat_cnt <= LAT_LOAD;
            end
          end
          S_WAIT: begin
            if (lat_cnt == 4'd0) begin
              state     <= S_OUTPUT;
              out_valid <= 1'b1;
            end else begin
              lat_cnt <= lat_cnt - 4'd1;
            end
          end
          S_OUTPUT: begin
            if (out_valid && out_ready) begin
              out_valid <= 1'b0;
              if (mbnumber == LAST_MB) begin
                state      <= S_DONE;
                frame_done <= 1'b1;
              end else begin
                // Raster advance by column wrap; no divider needed.
                state        <= S_ISSUE;
                recon_enable <= 1'b1;
                mbnumber     <= mbnumber + 13'd1;
                if (mb_col == LAST_COL) begin
                  mb_col     <= '0;
                  mb_row     <= mb_row + 8'd1;
                  left_avail <= 1'b0;
                  top_avail  <= 1'b1;
                end else begin
                  mb_col     <= mb_col + 8'd1;
                  left_avail <= 1'b1;
                end
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef RECON_PERF_EN
  // Backpressure counter: saturates, cleared only by an accepted start,
  // so the value of the last frame stays readable after frame_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (state == S_IDLE && frame_start) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule
